// File: rtl/shift_row_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_row_pipe
// Description : Registered ShiftRows / InvShiftRows stage for an AES/Rijndael
//               round datapath with Nb = 4, 6 or 8 columns. Valid/ready
//               handshake on both sides with a two-entry (main + skid)
//               buffer so the pipeline can stall without bubbles.
//               Optional per-byte even-parity protection is built when the
//               macro SHIFT_ROW_PARITY_EN is defined (adds in_par / par_err).
// Revision    : 1.0 - initial release
// ============================================================================
//
// Byte layout: byte k sits in the k-th byte counting from the most
// significant end of the vector (so a hex literal reads byte 0 first).
// Byte k is row k%4, column k/4.

module shift_row_pipe #(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef SHIFT_ROW_PARITY_EN
    ,
    input  logic [NB*4-1:0] in_par,
    output logic            par_err
`endif
);

    localparam int NBYTES = 4 * NB;

    // Encoding mirrors the buffer valid bits: bit0 = M.valid, bit1 = S.valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    // Only 4/6/8 columns are meaningful for Rijndael; W must stay derived.
    if (!((NB == 4) || (NB == 6) || (NB == 8)) || (W != 32 * NB)) begin : g_bad_cfg
        $error("shift_row_pipe: NB must be 4, 6 or 8 and W must equal 32*NB");
    end

    state_t         state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic [W-1:0]   m_data_q, m_data_d;
    logic [W-1:0]   s_data_q, s_data_d;
    logic [W-1:0]   perm_fwd;
    logic [W-1:0]   perm_inv;
    logic [W-1:0]   perm_data;
    logic           accept;

`ifdef SHIFT_ROW_PARITY_EN
    logic [NBYTES-1:0] m_par_q, m_par_d;
    logic [NBYTES-1:0] s_par_q, s_par_d;
    logic [NBYTES-1:0] par_fwd;
    logic [NBYTES-1:0] par_inv;
    logic [NBYTES-1:0] perm_par;
    logic [NBYTES-1:0] byte_err;
`endif

    // Pure wiring permutation: each output byte picks its source byte in the
    // same row, offset by C(r) columns (left for forward, right for inverse).
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = ((NB == 8) && (r >= 2)) ? r + 1 : r;
            localparam int DST = 4 * c + r;
            localparam int SF  = 4 * ((c + OFF) % NB) + r;
            localparam int SI  = 4 * ((c + NB - OFF) % NB) + r;
            assign perm_fwd[W-1-8*DST -: 8] = in_data[W-1-8*SF -: 8];
            assign perm_inv[W-1-8*DST -: 8] = in_data[W-1-8*SI -: 8];
`ifdef SHIFT_ROW_PARITY_EN
            assign par_fwd[DST] = in_par[SF];
            assign par_inv[DST] = in_par[SI];
`endif
        end
    end

    assign perm_data = in_inv ? perm_inv : perm_fwd;
    assign accept    = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = state_q[0];
    assign out_data  = m_data_q;

`ifdef SHIFT_ROW_PARITY_EN
    assign perm_par = in_inv ? par_inv : par_fwd;

    // Recompute even parity of every byte held in M and compare to the stored bit.
    for (genvar k = 0; k < NBYTES; k++) begin : g_par_chk
        assign byte_err[k] = (^m_data_q[W-1-8*k -: 8]) != m_par_q[k];
    end

    assign par_err = state_q[0] & (|byte_err);
`endif

    // Next-state and buffer steering: fill M first, spill to S only when M
    // is occupied and not draining; S refills M as soon as downstream accepts.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
`ifdef SHIFT_ROW_PARITY_EN
        m_par_d  = m_par_q;
        s_par_d  = s_par_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_data_d = perm_data;
`ifdef SHIFT_ROW_PARITY_EN
                    m_par_d  = perm_par;
`endif
                    state_d  = ST_HALF;
                end
            end
            ST_HALF: begin
                if (accept && out_ready) begin
                    m_data_d = perm_data;
`ifdef SHIFT_ROW_PARITY_EN
                    m_par_d  = perm_par;
`endif
                end else if (accept) begin
                    s_data_d = perm_data;
`ifdef SHIFT_ROW_PARITY_EN
                    s_par_d  = perm_par;
`endif
                    state_d  = ST_FULL;
                end else if (out_ready) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no accept can coincide.
                if (out_ready) begin
                    m_data_d = s_data_q;
`ifdef SHIFT_ROW_PARITY_EN
                    m_par_d  = s_par_q;
`endif
                    state_d  = ST_HALF;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // Buffer and handshake registers; reset discards any in-flight data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_data_q   <= '0;
            s_data_q   <= '0;
`ifdef SHIFT_ROW_PARITY_EN
            m_par_q    <= '0;
            s_par_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_data_q   <= m_data_d;
            s_data_q   <= s_data_d;
`ifdef SHIFT_ROW_PARITY_EN
            m_par_q    <= m_par_d;
            s_par_q    <= s_par_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_row_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_row_pipe
// Description : Directed self-checking bench for shift_row_pipe (NB=4 and
//               NB=8 instances). Parity checks are compiled in when
//               SHIFT_ROW_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_row_pipe;

    localparam logic [127:0] V1  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] E1  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VC  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [255:0] I8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] E8  = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    logic         clk;
    logic         rst;

    logic         v4, rdy4, inv4, ov4, ordy4;
    logic [127:0] d4, od4;
    logic         v8, rdy8, inv8, ov8, ordy8;
    logic [255:0] d8, od8;

`ifdef SHIFT_ROW_PARITY_EN
    logic [15:0]  par4;
    logic         perr4;
    logic [31:0]  par8;
    logic         perr8;
`endif

    int n_cmp;
    int n_fail;

    shift_row_pipe #(.NB(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .in_data   (d4),
        .in_inv    (inv4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .out_data  (od4)
`ifdef SHIFT_ROW_PARITY_EN
        ,
        .in_par    (par4),
        .par_err   (perr4)
`endif
    );

    shift_row_pipe #(.NB(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_data   (d8),
        .in_inv    (inv8),
        .out_valid (ov8),
        .out_ready (ordy8),
        .out_data  (od8)
`ifdef SHIFT_ROW_PARITY_EN
        ,
        .in_par    (par8),
        .par_err   (perr8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef SHIFT_ROW_PARITY_EN
    function automatic logic [15:0] par_of4(input logic [127:0] d);
        logic [15:0] p;
        for (int k = 0; k < 16; k++) p[k] = ^d[127-8*k -: 8];
        return p;
    endfunction
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst   = 1'b1;
        v4 = 1'b0; inv4 = 1'b0; ordy4 = 1'b0; d4 = '0;
        v8 = 1'b0; inv8 = 1'b0; ordy8 = 1'b0; d8 = '0;
`ifdef SHIFT_ROW_PARITY_EN
        par4 = '0;
        par8 = '0;
`endif
        step();
        step();
        chk("rst_out_valid", ov4, 0);
        chk("rst_in_ready", rdy4, 1);
        chk("rst_out_data", od4, 0);
        rst = 1'b0;

        // Forward then inverse back-to-back at full throughput.
        v4 = 1'b1; d4 = V1; inv4 = 1'b0; ordy4 = 1'b1;
`ifdef SHIFT_ROW_PARITY_EN
        par4 = par_of4(V1);
`endif
        step();
        chk("fwd_valid", ov4, 1);
        chk("fwd_data", od4, E1);
        d4 = E1; inv4 = 1'b1;
`ifdef SHIFT_ROW_PARITY_EN
        par4 = par_of4(E1);
        chk("par_ok", perr4, 0);
`endif
        step();
        chk("inv_data", od4, V1);
        chk("inv_ready", rdy4, 1);
        v4 = 1'b0;
        step();
        chk("drain_empty", ov4, 0);

        // Stall: three valids with out_ready low; only two fit.
        ordy4 = 1'b0;
        v4 = 1'b1; d4 = V1; inv4 = 1'b0;
        step();
        chk("stall1_ready", rdy4, 1);
        chk("stall1_data", od4, E1);
        d4 = E1; inv4 = 1'b1;
        step();
        chk("stall2_ready", rdy4, 0);
        d4 = VC; inv4 = 1'b0;
        step();
        chk("stall3_ready", rdy4, 0);
        chk("stall3_hold", od4, E1);
        chk("stall3_valid", ov4, 1);
        v4 = 1'b0; ordy4 = 1'b1;
        step();
        chk("rel1_data", od4, V1);
        chk("rel1_ready", rdy4, 1);
        chk("rel1_valid", ov4, 1);
        step();
        chk("rel2_empty", ov4, 0);

        // Asynchronous reset while FULL.
        ordy4 = 1'b0;
        v4 = 1'b1; d4 = V1; inv4 = 1'b0;
        step();
        d4 = E1; inv4 = 1'b1;
        step();
        chk("full_ready", rdy4, 0);
        v4 = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", ov4, 0);
        chk("arst_ready", rdy4, 1);
        chk("arst_data", od4, 0);
        #1;
        rst = 1'b0;
        v4 = 1'b1; d4 = VC; inv4 = 1'b0; ordy4 = 1'b1;
        d4 = V1;
        step();
        chk("post_rst_data", od4, E1);
        chk("post_rst_valid", ov4, 1);
        v4 = 1'b0;
        step();

`ifdef SHIFT_ROW_PARITY_EN
        // Corrupt the parity bit of byte 7 on one word only.
        v4 = 1'b1; d4 = V1; inv4 = 1'b0; par4 = par_of4(V1) ^ 16'h0080;
        step();
        chk("par_bad", perr4, 1);
        d4 = E1; inv4 = 1'b1; par4 = par_of4(E1);
        step();
        chk("par_clean", perr4, 0);
        v4 = 1'b0;
        step();
        chk("par_idle", perr4, 0);
`endif

        // NB=8 forward then inverse.
        v8 = 1'b1; d8 = I8; inv8 = 1'b0; ordy8 = 1'b1;
        step();
        chk("nb8_fwd", od8, E8);
        chk("nb8_valid", ov8, 1);
        d8 = E8; inv8 = 1'b1;
        step();
        chk("nb8_inv", od8, I8);
        v8 = 1'b0;
        step();
        chk("nb8_empty", ov8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
